// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard modes, total helpers, polarity constants.
package vga_pkg;

    localparam bit POL_NEG = 1'b0;  // active-low sync pulse
    localparam bit POL_POS = 1'b1;  // active-high sync pulse

    typedef struct packed {
        int unsigned act;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        bit          pol;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_mode_t;

    function automatic int unsigned vga_total(int unsigned sync, int unsigned bp,
                                              int unsigned act, int unsigned fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int unsigned axis_total(vga_axis_t a);
        return vga_total(a.sync, a.bp, a.act, a.fp);
    endfunction

    localparam vga_mode_t VGA_640X480_60 = '{
        h: '{act: 640, fp: 16, sync: 96, bp: 48, pol: POL_NEG},
        v: '{act: 480, fp: 10, sync: 2, bp: 33, pol: POL_NEG}
    };

    localparam vga_mode_t VGA_800X600_60 = '{
        h: '{act: 800, fp: 40, sync: 128, bp: 88, pol: POL_POS},
        v: '{act: 600, fp: 1, sync: 4, bp: 23, pol: POL_POS}
    };

    localparam vga_mode_t VGA_1024X768_60 = '{
        h: '{act: 1024, fp: 24, sync: 136, bp: 160, pol: POL_NEG},
        v: '{act: 768, fp: 3, sync: 6, bp: 29, pol: POL_NEG}
    };

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enable qualified shift register; resets every stage to RST_VAL. DEPTH=0 is a wire.
module vga_sync_delay #(
    parameter int unsigned     DEPTH   = 1,
    parameter int unsigned     WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, ce};
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Shift one stage per enabled cycle, otherwise hold.
        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (ce) begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        // Stage registers, filled with the inactive value on reset.
        always_ff @(posedge clk) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rst) begin
                    stage_q[i] <= RST_VAL;
                end else begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel repeat, linear VRAM address and sync delay.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT      = VGA_640X480_60.h.act,
    parameter int unsigned H_FP       = VGA_640X480_60.h.fp,
    parameter int unsigned H_SYNC     = VGA_640X480_60.h.sync,
    parameter int unsigned H_BP       = VGA_640X480_60.h.bp,
    parameter int unsigned V_ACT      = VGA_640X480_60.v.act,
    parameter int unsigned V_FP       = VGA_640X480_60.v.fp,
    parameter int unsigned V_SYNC     = VGA_640X480_60.v.sync,
    parameter int unsigned V_BP       = VGA_640X480_60.v.bp,
    parameter bit          H_POL      = VGA_640X480_60.h.pol,
    parameter bit          V_POL      = VGA_640X480_60.v.pol,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned PIPE_DLY   = 1,
    parameter int unsigned AW         = 19,
    parameter int unsigned CW         = 10,
    parameter int unsigned RW         = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [AW-1:0] vram_addr,
    output logic          vram_re,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOT = vga_total(H_SYNC, H_BP, H_ACT, H_FP);
    localparam int unsigned V_TOT = vga_total(V_SYNC, V_BP, V_ACT, V_FP);
    localparam int unsigned HW    = $clog2(H_TOT + 1);
    localparam int unsigned VW    = $clog2(V_TOT + 1);

    localparam logic [HW-1:0] HSyncEnd = HW'(H_SYNC);
    localparam logic [HW-1:0] HActBeg  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] HActEnd  = HW'(H_SYNC + H_BP + H_ACT);
    localparam logic [HW-1:0] HActLast = HW'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [HW-1:0] HLast    = HW'(H_TOT - 1);
    localparam logic [VW-1:0] VSyncEnd = VW'(V_SYNC);
    localparam logic [VW-1:0] VActBeg  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] VActEnd  = VW'(V_SYNC + V_BP + V_ACT);
    localparam logic [VW-1:0] VLast    = VW'(V_TOT - 1);
    localparam logic [2:0]    RepMax   = 3'((1 << SCALE_LOG2) - 1);

    if (H_ACT == 0 || V_ACT == 0 || H_SYNC == 0 || V_SYNC == 0 || AW == 0 || CW == 0 ||
        RW == 0) begin : g_bad_width
        $error("vga_timing_gen: active, sync and port widths must be non-zero");
    end
    if (SCALE_LOG2 > 3 || PIPE_DLY > 7) begin : g_bad_range
        $error("vga_timing_gen: SCALE_LOG2 must be 0..3 and PIPE_DLY 0..7");
    end
    if ((H_ACT % (1 << SCALE_LOG2)) != 0 || (V_ACT % (1 << SCALE_LOG2)) != 0) begin : g_bad_scale
        $error("vga_timing_gen: active size must be a multiple of the repeat factor");
    end
    if (64'(H_ACT >> SCALE_LOG2) > (64'd1 << CW) ||
        64'(V_ACT >> SCALE_LOG2) > (64'd1 << RW)) begin : g_bad_colrow
        $error("vga_timing_gen: scaled active size does not fit CW/RW");
    end
    if (64'(H_ACT >> SCALE_LOG2) * 64'(V_ACT >> SCALE_LOG2) > (64'd1 << AW)) begin : g_bad_aw
        $error("vga_timing_gen: scaled frame does not fit AW");
    end

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [2:0]    hrep_q, hrep_d, vrep_q, vrep_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d, col_q, col_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d, row_q, row_d;
    logic [AW-1:0] addr_cnt_q, addr_cnt_d, line_base_q, line_base_d, addr_q, addr_d;
    logic          vram_re_q, vram_re_d, hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          act_now, frame_wrap;

    assign act_now    = (h_q >= HActBeg) && (h_q < HActEnd) && (v_q >= VActBeg) && (v_q < VActEnd);
    assign frame_wrap = (h_q == HLast) && (v_q == VLast);

    // Raster counters plus the source-pixel counters describing the pixel at (h, v).
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        hrep_d      = hrep_q;
        vrep_d      = vrep_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        addr_cnt_d  = addr_cnt_q;
        line_base_d = line_base_q;
        if (pix_ce) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            if (act_now) begin
                if (hrep_q == RepMax) begin
                    hrep_d     = '0;
                    col_cnt_d  = col_cnt_q + 1'b1;
                    addr_cnt_d = addr_cnt_q + 1'b1;
                end else begin
                    hrep_d = hrep_q + 1'b1;
                end
                if (h_q == HActLast) begin
                    col_cnt_d = '0;
                    hrep_d    = '0;
                    if (vrep_q != RepMax) begin
                        // Same source line again: rewind to its first address.
                        vrep_d     = vrep_q + 1'b1;
                        addr_cnt_d = line_base_q;
                    end else begin
                        vrep_d      = '0;
                        line_base_d = addr_cnt_q + 1'b1;
                        row_cnt_d   = row_cnt_q + 1'b1;
                    end
                end
            end
            if (frame_wrap) begin
                hrep_d      = '0;
                vrep_d      = '0;
                col_cnt_d   = '0;
                row_cnt_d   = '0;
                addr_cnt_d  = '0;
                line_base_d = '0;
            end
        end
    end

    // Raw output stage: decoded from the current counters, held while pix_ce is low.
    always_comb begin
        vram_re_d     = vram_re_q;
        col_d         = col_q;
        row_d         = row_q;
        addr_d        = addr_q;
        hs_raw_d      = hs_raw_q;
        vs_raw_d      = vs_raw_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            vram_re_d     = act_now;
            col_d         = act_now ? col_cnt_q : '0;
            row_d         = act_now ? row_cnt_q : '0;
            addr_d        = act_now ? addr_cnt_q : '0;
            hs_raw_d      = (h_q < HSyncEnd) ? H_POL : ~H_POL;
            vs_raw_d      = (v_q < VSyncEnd) ? V_POL : ~V_POL;
            line_start_d  = (h_q == '0);
            frame_start_d = (h_q == '0) && (v_q == '0);
        end
    end

    // State and raw-stage registers with synchronous reset to frame top.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            hrep_q        <= '0;
            vrep_q        <= '0;
            col_cnt_q     <= '0;
            row_cnt_q     <= '0;
            addr_cnt_q    <= '0;
            line_base_q   <= '0;
            vram_re_q     <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            hs_raw_q      <= ~H_POL;
            vs_raw_q      <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hrep_q        <= hrep_d;
            vrep_q        <= vrep_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            line_base_q   <= line_base_d;
            vram_re_q     <= vram_re_d;
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Align display enable and syncs with VRAM read data.
    vga_sync_delay #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL ({1'b0, ~H_POL, ~V_POL})
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .ce   (pix_ce),
        .din  ({vram_re_q, hs_raw_q, vs_raw_q}),
        .dout ({active, hsync, vsync})
    );

    assign col         = col_q;
    assign row         = row_q;
    assign vram_addr   = addr_q;
    assign vram_re     = vram_re_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three differently configured generators on a small raster, compared
// every cycle against a model that derives outputs from the count of enabled cycles.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int CW = 5;
    localparam int RW = 4;
    localparam int AW = 8;
    localparam int ND = 3;
    localparam int OW = 6 + CW + RW + AW;
    localparam int RE_B = OW - 1;
    localparam int ACT_B = OW - 2;
    localparam int HS_B = OW - 3;
    localparam int VS_B = OW - 4;
    localparam int FS_B = OW - 6;
    localparam int SCL [ND] = '{0, 1, 2};
    localparam int DLY [ND] = '{1, 3, 0};
    localparam bit HPOL [ND] = '{1'b0, 1'b1, 1'b0};
    localparam bit VPOL [ND] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b0;
    logic [OW-1:0] obs [ND];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic [AW-1:0] vram_addr;
        logic vram_re, active, hsync, vsync, line_start, frame_start;

        vga_timing_gen #(
            .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .H_POL(HPOL[g]), .V_POL(VPOL[g]),
            .SCALE_LOG2(SCL[g]), .PIPE_DLY(DLY[g]),
            .AW(AW), .CW(CW), .RW(RW)
        ) u_dut (
            .clk(clk), .rst(rst), .pix_ce(pix_ce),
            .col(col), .row(row), .vram_addr(vram_addr),
            .vram_re(vram_re), .active(active), .hsync(hsync), .vsync(vsync),
            .line_start(line_start), .frame_start(frame_start)
        );

        assign obs[g] = {vram_re, active, hsync, vsync, line_start, frame_start,
                         col, row, vram_addr};
    end

    // Reference model: n = enabled cycles since reset; raw values follow from n alone.
    int n;
    bit m_re [ND];
    bit m_ls [ND];
    bit m_fs [ND];
    int m_col [ND];
    int m_row [ND];
    int m_addr [ND];
    logic [2:0] m_hist [ND][8];  // {active, hsync, vsync} of recent raw updates, newest first

    function automatic logic [OW-1:0] exp_of(int g);
        logic [2:0] d;
        d = m_hist[g][DLY[g]];
        return {m_re[g], d, m_ls[g], m_fs[g], CW'(m_col[g]), RW'(m_row[g]), AW'(m_addr[g])};
    endfunction

    function automatic logic [OW-1:0] rst_vec(int g);
        return {1'b0, 1'b0, ~HPOL[g], ~VPOL[g], 2'b00, {(CW + RW + AW){1'b0}}};
    endfunction

    task automatic model_reset();
        n = 0;
        for (int g = 0; g < ND; g++) begin
            m_re[g] = 1'b0;
            m_ls[g] = 1'b0;
            m_fs[g] = 1'b0;
            m_col[g] = 0;
            m_row[g] = 0;
            m_addr[g] = 0;
            for (int k = 0; k < 8; k++) m_hist[g][k] = {1'b0, ~HPOL[g], ~VPOL[g]};
        end
    endtask

    task automatic model_ce();
        int h, v;
        bit act;
        h = n % HT;
        v = (n / HT) % VT;
        act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        for (int g = 0; g < ND; g++) begin
            m_re[g] = act;
            m_col[g] = act ? (h - HS - HB) >> SCL[g] : 0;
            m_row[g] = act ? (v - VS - VB) >> SCL[g] : 0;
            m_addr[g] = m_row[g] * (HA >> SCL[g]) + m_col[g];
            m_ls[g] = (h == 0);
            m_fs[g] = (h == 0) && (v == 0);
            for (int k = 7; k > 0; k--) m_hist[g][k] = m_hist[g][k-1];
            m_hist[g][0] = {act, (h < HS) ? HPOL[g] : ~HPOL[g], (v < VS) ? VPOL[g] : ~VPOL[g]};
        end
        n++;
    endtask

    task automatic model_idle();
        for (int g = 0; g < ND; g++) begin
            m_ls[g] = 1'b0;
            m_fs[g] = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample 1 time unit later.
    task automatic step(input bit r, input bit ce);
        rst = r;
        pix_ce = ce;
        @(posedge clk);
        if (r) model_reset();
        else if (ce) model_ce();
        else model_idle();
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int g = 0; g < ND; g++) begin
            total++;
            if (obs[g] !== rst_vec(g)) begin
                bad++;
                $display("FAIL reset_values dut%0d got=%h exp=%h", g, obs[g], rst_vec(g));
            end
        end
    endtask

    task automatic test_full_frame();
        int last_fs, run_len, re_cnt, first_re;
        bit prev_hs;
        int max_addr [ND];
        last_fs = -1; run_len = 0; re_cnt = 0; first_re = -1; prev_hs = 1'b1;
        for (int g = 0; g < ND; g++) max_addr[g] = -1;
        step(1'b1, 1'b1);
        for (int c = 1; c <= 2 * FT + 5; c++) begin
            step(1'b0, 1'b1);
            for (int g = 0; g < ND; g++) begin
                total++;
                if (obs[g] !== exp_of(g)) begin
                    bad++;
                    $display("FAIL frame dut%0d c=%0d got=%h exp=%h", g, c, obs[g], exp_of(g));
                end
                if (c <= FT && obs[g][RE_B] && int'(obs[g][AW-1:0]) > max_addr[g])
                    max_addr[g] = int'(obs[g][AW-1:0]);
            end
            if (obs[0][FS_B]) begin
                if (last_fs >= 0) begin
                    total++;
                    if (c - last_fs != FT) begin
                        bad++;
                        $display("FAIL frame_period got=%0d exp=%0d", c - last_fs, FT);
                    end
                end
                last_fs = c;
            end
            if (!obs[0][HS_B]) begin
                run_len++;
            end else if (!prev_hs) begin
                total++;
                if (run_len != HS) begin
                    bad++;
                    $display("FAIL hsync_width c=%0d got=%0d exp=%0d", c, run_len, HS);
                end
                run_len = 0;
            end
            prev_hs = obs[0][HS_B];
            if (c <= FT && obs[0][RE_B]) re_cnt++;
            if (first_re < 0 && obs[0][RE_B]) begin
                first_re = c;
                total++;
                if (c != (VS + VB) * HT + HS + HB + 1 || obs[0][AW-1:0] !== '0) begin
                    bad++;
                    $display("FAIL first_pixel got c=%0d addr=%0d exp c=%0d addr=0", c,
                             obs[0][AW-1:0], (VS + VB) * HT + HS + HB + 1);
                end
            end
        end
        total++;
        if (re_cnt != HA * VA) begin
            bad++;
            $display("FAIL active_count got=%0d exp=%0d", re_cnt, HA * VA);
        end
        for (int g = 0; g < ND; g++) begin
            total++;
            if (max_addr[g] != (HA >> SCL[g]) * (VA >> SCL[g]) - 1) begin
                bad++;
                $display("FAIL last_addr dut%0d got=%0d exp=%0d", g, max_addr[g],
                         (HA >> SCL[g]) * (VA >> SCL[g]) - 1);
            end
        end
    endtask

    task automatic test_pipe_lag();
        int re_rise [ND];
        int act_rise [ND];
        int hs_hi1, hs_lo0;
        hs_hi1 = 0; hs_lo0 = 0;
        for (int g = 0; g < ND; g++) begin
            re_rise[g] = -1;
            act_rise[g] = -1;
        end
        step(1'b1, 1'b1);
        for (int c = 1; c <= 6 * HT; c++) begin
            step(1'b0, 1'b1);
            for (int g = 0; g < ND; g++) begin
                total++;
                if (obs[g] !== exp_of(g)) begin
                    bad++;
                    $display("FAIL lag_run dut%0d c=%0d got=%h exp=%h", g, c, obs[g], exp_of(g));
                end
                if (re_rise[g] < 0 && obs[g][RE_B]) re_rise[g] = c;
                if (act_rise[g] < 0 && obs[g][ACT_B]) act_rise[g] = c;
            end
            if (c <= HT && obs[1][HS_B]) hs_hi1++;
            if (c <= HT && !obs[0][HS_B]) hs_lo0++;
        end
        for (int g = 0; g < ND; g++) begin
            total++;
            if (re_rise[g] < 0 || act_rise[g] - re_rise[g] != DLY[g]) begin
                bad++;
                $display("FAIL pipe_lag dut%0d got=%0d exp=%0d", g, act_rise[g] - re_rise[g],
                         DLY[g]);
            end
        end
        total++;
        if (hs_hi1 != HS || hs_lo0 != HS) begin
            bad++;
            $display("FAIL hsync_polarity got hi1=%0d lo0=%0d exp=%0d", hs_hi1, hs_lo0, HS);
        end
    endtask

    task automatic test_ce_toggle();
        int last_fs, re_cnt;
        last_fs = -1; re_cnt = 0;
        step(1'b1, 1'b1);
        for (int c = 1; c <= 4 * FT + 4; c++) begin
            step(1'b0, c % 2 == 1);
            for (int g = 0; g < ND; g++) begin
                total++;
                if (obs[g] !== exp_of(g)) begin
                    bad++;
                    $display("FAIL ce_toggle dut%0d c=%0d got=%h exp=%h", g, c, obs[g],
                             exp_of(g));
                end
            end
            if (c <= 2 * FT && obs[0][RE_B]) re_cnt++;
            if (obs[0][FS_B]) begin
                if (last_fs >= 0) begin
                    total++;
                    if (c - last_fs != 2 * FT) begin
                        bad++;
                        $display("FAIL ce_frame_period got=%0d exp=%0d", c - last_fs, 2 * FT);
                    end
                end
                last_fs = c;
            end
        end
        total++;
        if (re_cnt != 2 * HA * VA) begin
            bad++;
            $display("FAIL ce_active_count got=%0d exp=%0d", re_cnt, 2 * HA * VA);
        end
    endtask

    task automatic test_random_ce();
        bit r, ce;
        step(1'b1, 1'b1);
        for (int c = 1; c <= 1500; c++) begin
            r = ($urandom_range(0, 499) == 0);
            ce = ($urandom_range(0, 3) != 0);
            step(r, ce);
            for (int g = 0; g < ND; g++) begin
                total++;
                if (obs[g] !== exp_of(g)) begin
                    bad++;
                    $display("FAIL random dut%0d c=%0d got=%h exp=%h", g, c, obs[g], exp_of(g));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int re_cnt;
        re_cnt = 0;
        step(1'b1, 1'b1);
        for (int c = 1; c <= 7 * HT + 12; c++) step(1'b0, 1'b1);
        total++;
        if (obs[0][RE_B] !== 1'b1) begin
            bad++;
            $display("FAIL mid_active got=%b exp=1", obs[0][RE_B]);
        end
        step(1'b1, 1'b1);
        for (int g = 0; g < ND; g++) begin
            total++;
            if (obs[g] !== rst_vec(g)) begin
                bad++;
                $display("FAIL mid_reset dut%0d got=%h exp=%h", g, obs[g], rst_vec(g));
            end
        end
        for (int c = 1; c <= FT; c++) begin
            step(1'b0, 1'b1);
            for (int g = 0; g < ND; g++) begin
                total++;
                if (obs[g] !== exp_of(g)) begin
                    bad++;
                    $display("FAIL restart dut%0d c=%0d got=%h exp=%h", g, c, obs[g],
                             exp_of(g));
                end
            end
            if (obs[0][RE_B]) re_cnt++;
        end
        total++;
        if (re_cnt != HA * VA) begin
            bad++;
            $display("FAIL restart_count got=%0d exp=%0d", re_cnt, HA * VA);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_pipe_lag();
        test_ce_toggle();
        test_random_ce();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
